// File: rtl/zp_accum_seq.sv
// Zero-predictor accumulator: reads B/DQ tap pairs from the bank, FMULTs each and sums into SEZI/SEZ.
// Optional feature macro ZP_POLE_TAPS_EN: also reads the pole taps (A2/SR2, A1/SR1) and drives se.
module zp_accum_seq #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       b_data,
    input  logic [10:0]       dq_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sezi,
    output logic [15:0]       sez,
`ifdef ZP_POLE_TAPS_EN
    output logic [15:0]       se,
`endif
    input  logic              scan_in0,
    input  logic              scan_in1,
    input  logic              scan_in2,
    input  logic              scan_in3,
    input  logic              scan_in4,
    input  logic              scan_enable,
    input  logic              test_mode,
    output logic              scan_out0,
    output logic              scan_out1,
    output logic              scan_out2,
    output logic              scan_out3,
    output logic              scan_out4
);

`ifdef ZP_POLE_TAPS_EN
    localparam int unsigned N_TAPS = 8;
`else
    localparam int unsigned N_TAPS = 6;
`endif
    localparam int unsigned N_ZERO_TAPS = 6;
    localparam int unsigned PIPE_W      = RD_LAT * ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N_TAPS - 1);
    localparam logic [ADDR_W-1:0] ZERO_END = ADDR_W'(N_ZERO_TAPS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_d;

    logic [RD_LAT-1:0]             vld_pipe;
    logic [RD_LAT-1:0][ADDR_W-1:0] tap_pipe;
    logic                          ret_valid, ret_last, ret_zero;
    logic [ADDR_W-1:0]             ret_tap;

    logic        an_s, sr_s, ws;
    logic [12:0] an_mag;
    logic [3:0]  an_exp, sr_exp;
    logic [5:0]  an_mant, sr_mant;
    logic [4:0]  wexp;
    logic [7:0]  wmant;
    logic [14:0] wmag;
    logic [15:0] w;

    logic [15:0] acc_z, acc_z_d;
`ifdef ZP_POLE_TAPS_EN
    logic [15:0] acc_all, acc_all_d;
`endif

    logic unused_dft;
    assign unused_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                          scan_enable, test_mode, b_data[1:0]};

    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

    // Read-return tracking: the issue strobe/address delayed to line up with bank data
    assign ret_valid = vld_pipe[RD_LAT-1];
    assign ret_tap   = tap_pipe[RD_LAT-1];
    assign ret_last  = ret_valid && (ret_tap == LAST_TAP);
    assign ret_zero  = ret_tap < ZERO_END;

    // FMULT of the returned coefficient with the returned float DQ
    always_comb begin
        an_s    = b_data[15];
        an_mag  = an_s ? 13'(13'd0 - b_data[14:2]) : b_data[14:2];
        an_exp  = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (an_mag[i]) an_exp = 4'(i + 1);
        end
        an_mant = (an_mag == 13'd0) ? 6'd32 : 6'({an_mag, 6'b0} >> an_exp);
        sr_s    = dq_data[10];
        sr_exp  = dq_data[9:6];
        sr_mant = dq_data[5:0];
        ws      = an_s ^ sr_s;
        wexp    = 5'(an_exp) + 5'(sr_exp);
        wmant   = 8'((12'(an_mant) * 12'(sr_mant) + 12'd48) >> 4);
        wmag    = (wexp > 5'd26) ? 15'({wmant, 7'b0} << (wexp - 5'd26))
                                 : 15'({wmant, 7'b0} >> (5'd26 - wexp));
        w       = ws ? 16'(16'd0 - 16'(wmag)) : 16'(wmag);
    end

    always_comb begin
        acc_z_d = acc_z;
`ifdef ZP_POLE_TAPS_EN
        acc_all_d = acc_all;
        if (ret_valid) acc_all_d = acc_all + w;
`endif
        if (ret_valid && ret_zero) acc_z_d = acc_z + w;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        addr_d  = '0;
        case (state)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: begin
                if (rd_addr == LAST_TAP) state_d = S_DRAIN;
                else                     addr_d  = rd_addr + ADDR_W'(1);
            end
            S_DRAIN: if (ret_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs, read-return pipeline and accumulators
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sezi     <= '0;
            sez      <= '0;
            acc_z    <= '0;
            vld_pipe <= '0;
            tap_pipe <= '0;
`ifdef ZP_POLE_TAPS_EN
            se       <= '0;
            acc_all  <= '0;
`endif
        end else begin
            rd_en    <= (state_d == S_ISSUE);
            rd_addr  <= addr_d;
            busy     <= (state_d != S_IDLE);
            done     <= (state_d == S_DONE);
            vld_pipe <= RD_LAT'({vld_pipe, rd_en});
            tap_pipe <= PIPE_W'({tap_pipe, rd_addr});
            if (state == S_IDLE && start) acc_z <= '0;
            else                          acc_z <= acc_z_d;
`ifdef ZP_POLE_TAPS_EN
            if (state == S_IDLE && start) acc_all <= '0;
            else                          acc_all <= acc_all_d;
            if (state_d == S_DONE) se <= {acc_all_d[15], acc_all_d[15:1]};
`endif
            if (state_d == S_DONE) begin
                sezi <= acc_z_d;
                sez  <= {acc_z_d[15], acc_z_d[15:1]};
            end
        end
    end

endmodule

// File: tb/tb_zp_accum_seq.sv
// Directed bench for zp_accum_seq: one instance per bank latency (1 and 2) sharing start/reset.
module tb_zp_accum_seq;

`ifdef ZP_POLE_TAPS_EN
    localparam int N_TAPS = 8;
`else
    localparam int N_TAPS = 6;
`endif
    localparam int LAT1 = N_TAPS + 2;
    localparam int LAT2 = N_TAPS + 3;

    typedef struct {
        string               name;
        logic [7:0][15:0]    b;
        logic [7:0][10:0]    dq;
        logic [15:0]         sezi;
        logic [15:0]         sez;
        logic [15:0]         se;
    } vec_t;

    logic clk, reset, start;
    logic        rd_en1, rd_en2, busy1, busy2, done1, done2;
    logic [2:0]  rd_addr1, rd_addr2;
    logic [15:0] b1, b2, b2s, sezi1, sezi2, sez1, sez2;
    logic [10:0] dq1, dq2, dq2s;
    logic [4:0]  so1, so2;
`ifdef ZP_POLE_TAPS_EN
    logic [15:0] se1, se2;
`endif

    logic [15:0] b_mem [8];
    logic [10:0] dq_mem [8];
    logic [2:0]  addr_q [$];
    vec_t        vecs [7];
    int          n_cmp, n_bad;

    zp_accum_seq #(.RD_LAT(1), .ADDR_W(3)) dut1 (
        .clk(clk), .reset(reset), .start(start), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .b_data(b1), .dq_data(dq1), .busy(busy1), .done(done1), .sezi(sezi1), .sez(sez1),
`ifdef ZP_POLE_TAPS_EN
        .se(se1),
`endif
        .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
        .scan_enable(1'b0), .test_mode(1'b0),
        .scan_out0(so1[0]), .scan_out1(so1[1]), .scan_out2(so1[2]), .scan_out3(so1[3]),
        .scan_out4(so1[4])
    );

    zp_accum_seq #(.RD_LAT(2), .ADDR_W(3)) dut2 (
        .clk(clk), .reset(reset), .start(start), .rd_en(rd_en2), .rd_addr(rd_addr2),
        .b_data(b2), .dq_data(dq2), .busy(busy2), .done(done2), .sezi(sezi2), .sez(sez2),
`ifdef ZP_POLE_TAPS_EN
        .se(se2),
`endif
        .scan_in0(1'b1), .scan_in1(1'b1), .scan_in2(1'b1), .scan_in3(1'b1), .scan_in4(1'b1),
        .scan_enable(1'b1), .test_mode(1'b0),
        .scan_out0(so2[0]), .scan_out1(so2[1]), .scan_out2(so2[2]), .scan_out3(so2[3]),
        .scan_out4(so2[4])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank models; a poison value is driven whenever no read is returning
    always @(posedge clk) begin
        if (rd_en1) begin b1 <= b_mem[rd_addr1]; dq1 <= dq_mem[rd_addr1]; end
        else        begin b1 <= 16'h5A5A;        dq1 <= 11'h2E7;          end
    end
    always @(posedge clk) begin
        if (rd_en2) begin b2s <= b_mem[rd_addr2]; dq2s <= dq_mem[rd_addr2]; end
        else        begin b2s <= 16'h5A5A;        dq2s <= 11'h2E7;          end
        b2  <= b2s;
        dq2 <= dq2s;
    end

    always @(negedge clk) if (rd_en1) addr_q.push_back(rd_addr1);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit poke);
        int          lat1, lat2, nd1, nd2;
        logic [15:0] hold1;
        bit          partial_ok, busy_first, busy_done, addr_ok;
        for (int i = 0; i < 8; i++) begin
            b_mem[i]  = v.b[i];
            dq_mem[i] = v.dq[i];
        end
        lat1 = -1; lat2 = -1; nd1 = 0; nd2 = 0;
        hold1 = sezi1; partial_ok = 1'b1; busy_first = 1'b0; busy_done = 1'b0;
        @(negedge clk);
        addr_q.delete();
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                busy_first = busy1 && busy2;
            end
            if (done1) begin
                nd1++;
                if (lat1 < 0) begin lat1 = c; busy_done = busy1; end
            end else if (lat1 < 0 && sezi1 !== hold1) partial_ok = 1'b0;
            if (done2) begin
                nd2++;
                if (lat2 < 0) lat2 = c;
            end
            if (poke && (c == 3 || c == LAT1)) start = 1'b1;
            if (poke && (c == 4 || c == LAT1 + 1)) start = 1'b0;
        end
        chk({v.name, " lat1"}, 32'(lat1), 32'(LAT1));
        chk({v.name, " lat2"}, 32'(lat2), 32'(LAT2));
        chk({v.name, " dones"}, 32'({nd1[7:0], nd2[7:0]}), 32'h0101);
        chk({v.name, " sezi1"}, 32'(sezi1), 32'(v.sezi));
        chk({v.name, " sez1"}, 32'(sez1), 32'(v.sez));
        chk({v.name, " sezi2"}, 32'(sezi2), 32'(v.sezi));
        chk({v.name, " sez2"}, 32'(sez2), 32'(v.sez));
`ifdef ZP_POLE_TAPS_EN
        chk({v.name, " se1"}, 32'(se1), 32'(v.se));
        chk({v.name, " se2"}, 32'(se2), 32'(v.se));
`endif
        chk({v.name, " no partial"}, 32'(partial_ok), 32'd1);
        chk({v.name, " busy span"}, 32'({busy_first, busy_done, busy1, busy2}), 32'b1100);
        addr_ok = (addr_q.size() == N_TAPS);
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != 3'(i)) addr_ok = 1'b0;
        chk({v.name, " addr seq"}, 32'(addr_ok), 32'd1);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b1; start = 1'b0;

        vecs[0] = '{"pos",   {8{16'h4000}}, {8{11'h060}}, 16'h000C, 16'h0006, 16'h0008};
        vecs[1] = '{"neg",   {8{16'hC000}}, {8{11'h060}}, 16'hFFF4, 16'hFFFA, 16'hFFF8};
        vecs[2] = '{"alt",   {4{16'hC000, 16'h4000}}, {8{11'h060}}, 16'h0000, 16'h0000, 16'h0000};
        vecs[3] = '{"max26", {8{16'h7FFF}}, {8{11'h37F}}, 16'hF100, 16'hF880, 16'hF600};
        vecs[4] = '{"max28", {8{16'h7FFF}}, {8{11'h3FF}}, 16'hC400, 16'hE200, 16'hD800};
        vecs[5] = '{"zero",  {8{16'h0000}}, {8{11'h020}}, 16'h0000, 16'h0000, 16'h0000};
        vecs[6] = '{"mixed",
                    {16'h4000, 16'h4000, 16'h4000, 16'h2000, 16'h7FFF, 16'h7FFF, 16'h4000, 16'h4000},
                    {11'h060, 11'h060, 11'h0A0, 11'h060, 11'h77F, 11'h37F, 11'h460, 11'h060},
                    16'h0005, 16'h0002, 16'h0004};

        repeat (2) @(negedge clk);
        chk("reset ctl1", 32'({busy1, done1, rd_en1, rd_addr1}), 32'd0);
        chk("reset data1", {sezi1, sez1}, 32'd0);
        chk("reset ctl2", 32'({busy2, done2, rd_en2, rd_addr2}), 32'd0);
        chk("scan outs", 32'({so1, so2}), 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) run_vec(vecs[v], 1'b0);

        // Extra start pulses mid-run and in the done cycle must not restart or double-count
        run_vec(vecs[0], 1'b1);

        // Abort mid-issue with reset, then rerun with clean data
        for (int i = 0; i < 8; i++) begin b_mem[i] = vecs[1].b[i]; dq_mem[i] = vecs[1].dq[i]; end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort ctl1", 32'({busy1, done1, rd_en1, rd_addr1}), 32'd0);
        chk("abort data1", {sezi1, sez1}, 32'd0);
        chk("abort ctl2", 32'({busy2, done2, rd_en2, rd_addr2}), 32'd0);
        chk("abort data2", {sezi2, sez2}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[0], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
